fp_wb_scoreboard: RTL and testbench

//  Writeback stage and hazard scoreboard for the FP register file. Tracks one pending bit per FP

---
 rtl/fp_wb_scoreboard.sv | 152 +++++++++++++++
 tb/tb_fp_wb_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fp_wb_scoreboard
//  Purpose  : FP writeback arbiter with pending-register hazard scoreboard
//             and an in-order FPU result buffer.
//  Revision : 1.0  initial release
// ============================================================================
module fp_wb_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    input  logic [14:0]           issue_rs_i,
    input  logic [2:0]            issue_rs_use_i,
    output logic                  stall_o,
    input  logic                  ld_valid_i,
    input  logic [4:0]            ld_rd_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  fpu_valid_i,
    input  logic [4:0]            fpu_rd_i,
    input  logic [DATA_WIDTH-1:0] fpu_data_i,
    output logic                  fpu_ready_o,
    output logic                  regfile_we_o,
    output logic [4:0]            regfile_waddr_o,
    output logic [DATA_WIDTH-1:0] regfile_data_o,
    output logic [31:0]           pending_o,
    output logic                  err_o
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]           pending;
    logic [31:0]           pending_nxt;

    logic [4:0]            fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic                  fpu_xfer;
    logic                  enq;
    logic                  deq;
    logic                  accept;
    logic                  hazard;

    logic                  win_valid;
    logic [4:0]            win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == DEPTH_CNT);
    assign fpu_ready_o = ~fifo_full;
    assign fpu_xfer    = fpu_valid_i & fpu_ready_o;
    assign pending_o   = pending;

    // RAW on any used source, or WAW on the destination.
    assign hazard = pending[issue_rd_i]
                  | (issue_rs_use_i[0] & pending[issue_rs_i[4:0]])
                  | (issue_rs_use_i[1] & pending[issue_rs_i[9:5]])
                  | (issue_rs_use_i[2] & pending[issue_rs_i[14:10]]);
    assign stall_o = issue_valid_i & hazard;
    assign accept  = issue_valid_i & ~hazard;

    // Load first, then buffered FPU results, then a fresh FPU result
    // only if nothing older is queued (keeps FPU results in order).
    always_comb begin
        win_valid = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        deq       = 1'b0;
        if (ld_valid_i) begin
            win_valid = 1'b1;
            win_rd    = ld_rd_i;
            win_data  = ld_data_i;
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_rd    = fifo_rd[rd_ptr];
            win_data  = fifo_data[rd_ptr];
            deq       = 1'b1;
        end else if (fpu_xfer) begin
            win_valid = 1'b1;
            win_rd    = fpu_rd_i;
            win_data  = fpu_data_i;
        end
    end

    assign enq = fpu_xfer & (ld_valid_i | ~fifo_empty);

    // Set is applied after clear so a same-edge set wins.
    always_comb begin
        pending_nxt = pending;
        if (win_valid) begin
            pending_nxt[win_rd] = 1'b0;
        end
        if (accept) begin
            pending_nxt[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            regfile_we_o    <= 1'b0;
            regfile_waddr_o <= '0;
            regfile_data_o  <= '0;
            err_o           <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            regfile_we_o <= win_valid;
            if (win_valid) begin
                regfile_waddr_o <= win_rd;
                regfile_data_o  <= win_data;
                if (!pending[win_rd]) begin
                    err_o <= 1'b1;
                end
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= fpu_rd_i;
            fifo_data[wr_ptr] <= fpu_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_wb_scoreboard
//  Purpose  : Directed self-checking bench for fp_wb_scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_wb_scoreboard;

    localparam int DATA_WIDTH = 32;
    localparam int FIFO_DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  issue_valid = 1'b0;
    logic [4:0]            issue_rd = '0;
    logic [14:0]           issue_rs = '0;
    logic [2:0]            issue_rs_use = '0;
    logic                  stall;
    logic                  ld_valid = 1'b0;
    logic [4:0]            ld_rd = '0;
    logic [DATA_WIDTH-1:0] ld_data = '0;
    logic                  fpu_valid = 1'b0;
    logic [4:0]            fpu_rd = '0;
    logic [DATA_WIDTH-1:0] fpu_data = '0;
    logic                  fpu_ready;
    logic                  regfile_we;
    logic [4:0]            regfile_waddr;
    logic [DATA_WIDTH-1:0] regfile_data;
    logic [31:0]           pending;
    logic                  err;

    int errors = 0;
    int checks = 0;

    fp_wb_scoreboard #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid),
        .issue_rd_i     (issue_rd),
        .issue_rs_i     (issue_rs),
        .issue_rs_use_i (issue_rs_use),
        .stall_o        (stall),
        .ld_valid_i     (ld_valid),
        .ld_rd_i        (ld_rd),
        .ld_data_i      (ld_data),
        .fpu_valid_i    (fpu_valid),
        .fpu_rd_i       (fpu_rd),
        .fpu_data_i     (fpu_data),
        .fpu_ready_o    (fpu_ready),
        .regfile_we_o   (regfile_we),
        .regfile_waddr_o(regfile_waddr),
        .regfile_data_o (regfile_data),
        .pending_o      (pending),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_rs_use = 3'b000;
        tick();
        issue_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want %h", pending, 32'h0); end
        checks++; if (regfile_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", regfile_we); end
        checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", fpu_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (regfile_waddr !== 5'd0 || regfile_data !== 32'h0) begin
            errors++; $display("FAIL reset_wdata: got %h/%h want 00/00000000", regfile_waddr, regfile_data);
        end
        rst = 1'b0;
        tick();
        checks++; if (fpu_ready !== 1'b1 || regfile_we !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b we=%b want 1/0", fpu_ready, regfile_we);
        end
    endtask

    task automatic test_raw();
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rs_use = 3'b000;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue_stall: got %b want 0", stall); end
        tick();
        issue_rd = 5'd10; issue_rs = {5'd0, 5'd0, 5'd5}; issue_rs_use = 3'b001;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", stall); end
        checks++; if (pending !== 32'h0000_0020) begin errors++; $display("FAIL raw_pending5: got %h want %h", pending, 32'h20); end
        tick();
        fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h3F80_0000;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_hold: got %b want 1", stall); end
        tick();
        fpu_valid = 1'b0;
        #1;
        checks++; if (regfile_we !== 1'b1 || regfile_waddr !== 5'd5 || regfile_data !== 32'h3F80_0000) begin
            errors++; $display("FAIL raw_write: got we=%b %h/%h want 1 05/3f800000", regfile_we, regfile_waddr, regfile_data);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_unstall: got %b want 0", stall); end
        tick();
        issue_valid = 1'b0; issue_rs_use = 3'b000;
        checks++; if (pending !== 32'h0000_0400) begin errors++; $display("FAIL raw_pending10: got %h want %h", pending, 32'h400); end
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h0;
        tick();
        ld_valid = 1'b0;
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL raw_cleanup: got %h want 0", pending); end
    endtask

    task automatic test_collision();
        do_issue(5'd3);
        do_issue(5'd4);
        checks++; if (pending !== 32'h0000_0018) begin errors++; $display("FAIL col_pending: got %h want %h", pending, 32'h18); end
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h1111_1111;
        fpu_valid = 1'b1; fpu_rd = 5'd4; fpu_data = 32'h2222_2222;
        tick();
        ld_valid = 1'b0; fpu_valid = 1'b0;
        checks++; if (regfile_we !== 1'b1 || regfile_waddr !== 5'd3 || regfile_data !== 32'h1111_1111) begin
            errors++; $display("FAIL col_first: got we=%b %h/%h want 1 03/11111111", regfile_we, regfile_waddr, regfile_data);
        end
        tick();
        checks++; if (regfile_we !== 1'b1 || regfile_waddr !== 5'd4 || regfile_data !== 32'h2222_2222) begin
            errors++; $display("FAIL col_second: got we=%b %h/%h want 1 04/22222222", regfile_we, regfile_waddr, regfile_data);
        end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL col_pending_clear: got %h want 0", pending); end
        tick();
        checks++; if (regfile_we !== 1'b0) begin errors++; $display("FAIL col_idle: got %b want 0", regfile_we); end
    endtask

    task automatic test_fifo_full();
        logic [4:0]  fpu_rds [3];
        logic [4:0]  exp_w   [7];
        logic [4:0]  got_w   [16];
        logic [31:0] got_d   [16];
        int idx;
        int nw;
        logic acc;
        fpu_rds = '{5'd6, 5'd7, 5'd8};
        exp_w   = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd6, 5'd7, 5'd8};
        idx = 0;
        nw  = 0;
        for (int r = 6; r <= 8; r++) do_issue(5'(r));
        for (int r = 11; r <= 14; r++) do_issue(5'(r));
        for (int cyc = 0; cyc < 10; cyc++) begin
            ld_valid  = (cyc < 4);
            ld_rd     = 5'(11 + cyc);
            ld_data   = 32'hB000_0000 + 32'(cyc);
            fpu_valid = (idx < 3);
            fpu_rd    = (idx < 3) ? fpu_rds[idx] : 5'd0;
            fpu_data  = 32'hA000_0000 + 32'(fpu_rd);
            #1;
            if (cyc == 2) begin
                checks++; if (fpu_ready !== 1'b0 || idx != 2) begin
                    errors++; $display("FAIL fifo_full_ready: got ready=%b accepts=%0d want 0/2", fpu_ready, idx);
                end
            end
            acc = fpu_valid & fpu_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (regfile_we === 1'b1 && nw < 16) begin
                got_w[nw] = regfile_waddr;
                got_d[nw] = regfile_data;
                nw++;
            end
        end
        ld_valid = 1'b0; fpu_valid = 1'b0;
        checks++; if (nw != 7) begin errors++; $display("FAIL fifo_write_count: got %0d want 7", nw); end
        for (int k = 0; k < 7; k++) begin
            if (k < nw) begin
                checks++; if (got_w[k] !== exp_w[k]) begin
                    errors++; $display("FAIL fifo_order[%0d]: got %0d want %0d", k, got_w[k], exp_w[k]);
                end
            end
        end
        if (nw >= 7) begin
            checks++; if (got_d[6] !== 32'hA000_0008) begin
                errors++; $display("FAIL fifo_data_last: got %h want a0000008", got_d[6]);
            end
        end
        checks++; if (pending !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL fifo_final: got pending=%h err=%b want 0/0", pending, err);
        end
    endtask

    task automatic test_spurious();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0099;
        tick();
        ld_valid = 1'b0;
        checks++; if (regfile_we !== 1'b1 || regfile_waddr !== 5'd9 || regfile_data !== 32'h99) begin
            errors++; $display("FAIL spur_write: got we=%b %h/%h want 1 09/00000099", regfile_we, regfile_waddr, regfile_data);
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", err); end
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_async_reset();
        bit saw_write;
        for (int r = 20; r <= 23; r++) do_issue(5'(r));
        ld_valid = 1'b1; ld_rd = 5'd22; fpu_valid = 1'b1; fpu_rd = 5'd20; fpu_data = 32'hC000_0020;
        tick();
        ld_rd = 5'd23; fpu_rd = 5'd21; fpu_data = 32'hC000_0021;
        tick();
        ld_valid = 1'b0; fpu_valid = 1'b0;
        checks++; if (fpu_ready !== 1'b0 || pending !== 32'h0030_0000) begin
            errors++; $display("FAIL ar_prefill: got ready=%b pending=%h want 0/00300000", fpu_ready, pending);
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (regfile_we !== 1'b0 || pending !== 32'h0 || fpu_ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL ar_immediate: got we=%b pending=%h ready=%b err=%b want 0/0/1/0",
                               regfile_we, pending, fpu_ready, err);
        end
        checks++; if (regfile_waddr !== 5'd0 || regfile_data !== 32'h0) begin
            errors++; $display("FAIL ar_wdata: got %h/%h want 00/00000000", regfile_waddr, regfile_data);
        end
        tick();
        rst = 1'b0;
        saw_write = 1'b0;
        repeat (5) begin
            tick();
            if (regfile_we !== 1'b0) saw_write = 1'b1;
        end
        checks++; if (saw_write) begin errors++; $display("FAIL ar_no_drain: got write after reset want none"); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_collision();
        test_fifo_full();
        test_spurious();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
